// File: rtl/cim_pkg.sv
// Shared types and default widths for the CIM column datapath.
// Imported by the shift-accumulate stage and its arithmetic helper.
package cim_pkg;

  localparam int DEF_PSUM_W  = 20;
  localparam int DEF_ACC_W   = 36;
  localparam int DEF_IN_BITS = 8;

  typedef enum logic [1:0] {
    IDLE,
    ACC,
    DONE
  } acc_state_t;

  typedef logic signed [DEF_PSUM_W-1:0] psum_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

endpackage

// File: rtl/cim_acc_addsub.sv
// Shift, sign-extend and add/subtract one bit-plane partial sum.
// Flags lost significance on the shift and signed overflow on the add.
module cim_acc_addsub
  import cim_pkg::*;
#(
  parameter int PSUM_W = DEF_PSUM_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic [ACC_W-1:0]  acc,
  input  logic [PSUM_W-1:0] psum,
  input  logic              sub,
  input  logic              shift_en,
  output logic [ACC_W-1:0]  next_acc,
  output logic              ovf
);

  localparam int M = ACC_W - 1;

  logic [ACC_W-1:0] ext;
  logic [ACC_W-1:0] base;
  logic [ACC_W-1:0] sum;
  logic             shift_ovf;
  logic             add_ovf;
  logic             same_sign;

  assign ext = {{(ACC_W-PSUM_W){psum[PSUM_W-1]}}, psum};

  assign base = shift_en ? {acc[ACC_W-2:0], 1'b0} : acc;

  assign shift_ovf = shift_en & (acc[M] ^ acc[M-1]);

  assign sum = sub ? base - ext : base + ext;

  // Subtraction overflows only when operand signs differ.
  assign same_sign = ~(base[M] ^ ext[M]);
  assign add_ovf   = (sub ? ~same_sign : same_sign)
                   & (sum[M] ^ base[M]);

  assign next_acc = sum;
  assign ovf      = shift_ovf | add_ovf;

endmodule

// File: rtl/cim_shift_acc.sv
// Bit-serial shift-accumulate stage, MSB bit-plane first.
// Valid/ready on both sides; back-to-back frames at the output handshake.
module cim_shift_acc
  import cim_pkg::*;
#(
  parameter  int PSUM_W  = DEF_PSUM_W,
  parameter  int ACC_W   = DEF_ACC_W,
  parameter  int IN_BITS = DEF_IN_BITS,
  localparam int CNT_W   = $clog2(IN_BITS + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              start,
  input  logic              cfg_signed,
  input  logic [CNT_W-1:0]  cfg_planes,
  input  logic [PSUM_W-1:0] psum_data,
  input  logic              psum_valid,
  output logic              psum_ready,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);

  acc_state_t       state;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] planes;
  logic [CNT_W-1:0] cfg_eff;
  logic             sgn;
  logic             step_ovf;
  logic             accept;
  logic             first;
  logic             last;
  logic             go;

  assign cfg_eff = (cfg_planes == '0 ||
                    cfg_planes > CNT_W'(IN_BITS))
                 ? CNT_W'(IN_BITS) : cfg_planes;

  assign psum_ready = (state == ACC);
  assign busy       = (state != IDLE);
  assign accept     = psum_ready & psum_valid;
  assign first      = (cnt == '0);
  assign last       = (cnt + CNT_W'(1) == planes);

  // A new frame may open from IDLE or at the result handshake.
  assign go = start & ((state == IDLE) |
              ((state == DONE) & out_valid & out_ready));

  cim_acc_addsub #(
    .PSUM_W (PSUM_W),
    .ACC_W  (ACC_W)
  ) u_addsub (
    .acc      (acc),
    .psum     (psum_data),
    .sub      (first & sgn),
    .shift_en (~(first & sgn)),
    .next_acc (nxt),
    .ovf      (step_ovf)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      planes    <= '0;
      sgn       <= 1'b0;
      out_data  <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      acc       <= '0;
      cnt       <= '0;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else if (go) begin
      state     <= ACC;
      acc       <= '0;
      cnt       <= '0;
      planes    <= cfg_eff;
      sgn       <= cfg_signed;
      out_ovf   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        ACC: begin
          if (accept) begin
            acc     <= nxt;
            cnt     <= cnt + CNT_W'(1);
            out_ovf <= out_ovf | step_ovf;
            if (last) begin
              out_data  <= nxt;
              out_valid <= 1'b1;
              state     <= DONE;
            end
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cim_shift_acc.sv
// Self-checking bench for cim_shift_acc against an exact-arithmetic model.
// A second 24-bit accumulator instance shares all inputs for overflow cases.
module tb_cim_shift_acc;

  localparam int PW  = 20;
  localparam int AW  = 36;
  localparam int AW2 = 24;
  localparam int NB  = 8;
  localparam int CW  = $clog2(NB + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr = 1'b0;
  logic          start = 1'b0;
  logic          cfg_signed = 1'b0;
  logic [CW-1:0] cfg_planes = '0;
  logic [PW-1:0] psum_data = '0;
  logic          psum_valid = 1'b0;
  logic          out_ready = 1'b0;

  logic           psum_ready, out_ovf, out_valid, busy;
  logic [AW-1:0]  out_data;
  logic           psum_ready2, out_ovf2, out_valid2, busy2;
  logic [AW2-1:0] out_data2;

  int checks = 0;
  int failures = 0;
  int psq[NB];

  always #5 clk = ~clk;

  cim_shift_acc #(.PSUM_W(PW), .ACC_W(AW), .IN_BITS(NB)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
    .cfg_signed(cfg_signed), .cfg_planes(cfg_planes),
    .psum_data(psum_data), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .out_data(out_data),
    .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready), .busy(busy)
  );

  cim_shift_acc #(.PSUM_W(PW), .ACC_W(AW2), .IN_BITS(NB)) dut2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .start(start),
    .cfg_signed(cfg_signed), .cfg_planes(cfg_planes),
    .psum_data(psum_data), .psum_valid(psum_valid),
    .psum_ready(psum_ready2), .out_data(out_data2),
    .out_ovf(out_ovf2), .out_valid(out_valid2),
    .out_ready(out_ready), .busy(busy2)
  );

  function automatic int eff(input int np);
    return (np == 0 || np > NB) ? NB : np;
  endfunction

  // Exact dot product of weighted planes; overflow whenever an exact
  // intermediate leaves the signed w-bit range.
  function automatic void model(input int w, input bit sg, input int n,
                                output logic [63:0] d, output bit ov);
    longint a, hi, lo;
    a = 0;
    ov = 0;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -hi - 1;
    for (int i = 0; i < n; i++) begin
      if (i == 0 && sg) begin
        a = -longint'(psq[i]);
      end else begin
        a = a * 2;
        if (a > hi || a < lo) ov = 1;
        a = a + longint'(psq[i]);
        if (a > hi || a < lo) ov = 1;
      end
    end
    d = 64'(a) & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic begin_frame(input bit sg, input int np);
    start = 1'b1;
    cfg_signed = sg;
    cfg_planes = CW'(np);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic end_frame;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic feed(input int n, input int mode,
                      output bit to, output bit early);
    int k;
    int cyc;
    k = 0;
    cyc = 0;
    to = 0;
    early = 0;
    while (k < n && !to) begin
      case (mode)
        0:       psum_valid = 1'b1;
        1:       psum_valid = 1'($urandom_range(0, 1));
        default: psum_valid = (cyc % 3 == 0);
      endcase
      psum_data = psq[k][PW-1:0];
      if (out_valid) early = 1;
      if (psum_valid && psum_ready) k++;
      @(posedge clk); #1;
      cyc++;
      if (cyc > 500) to = 1;
    end
    psum_valid = 1'b0;
  endtask

  task automatic rand_psums(input int shr);
    logic signed [PW-1:0] t;
    for (int i = 0; i < NB; i++) begin
      t = PW'($urandom);
      psq[i] = int'(t) >>> shr;
    end
  endtask

  task automatic test_reset;
    #3;
    checks++;
    if (out_valid !== 1'b0 || psum_ready !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: v=%b r=%b b=%b want 0",
               out_valid, psum_ready, busy);
    end
    checks++;
    if (out_data !== '0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL reset_data: d=%h o=%b want 0", out_data, out_ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned;
    bit to, early;
    psq[0] = 1; psq[1] = 0; psq[2] = 1; psq[3] = 1;
    begin_frame(0, 4);
    feed(4, 0, to, early);
    checks++;
    if (to || early || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL uns_latency: v=%b early=%b to=%b want v=1",
               out_valid, early, to);
    end
    checks++;
    if (out_data !== 36'd11 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL uns_result: d=%0d o=%b want 11/0",
               out_data, out_ovf);
    end
    checks++;
    if (psum_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL uns_done: r=%b b=%b want 0/1", psum_ready, busy);
    end
    end_frame;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL uns_idle: v=%b b=%b want 0/0", out_valid, busy);
    end
  endtask

  task automatic test_signed;
    bit to, early;
    psq[0] = 1; psq[1] = 0; psq[2] = 1; psq[3] = 1;
    begin_frame(1, 4);
    feed(4, 0, to, early);
    checks++;
    if (to || out_valid !== 1'b1 || out_data !== 36'hF_FFFF_FFFB) begin
      failures++;
      $display("FAIL sgn_small: d=%h v=%b want fffffffb/1",
               out_data, out_valid);
    end
    end_frame;
    for (int i = 0; i < NB; i++) psq[i] = -524288;
    begin_frame(1, 8);
    feed(8, 0, to, early);
    checks++;
    if (to || out_data !== 36'd524288 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL sgn_min: d=%0d o=%b want 524288/0",
               out_data, out_ovf);
    end
    end_frame;
  endtask

  task automatic test_random;
    bit to, early, sg, ov, ov2;
    int np;
    logic [63:0] d, d2;
    for (int f = 0; f < 30; f++) begin
      sg = 1'($urandom);
      np = $urandom_range(0, 15);
      rand_psums((f % 2) ? 0 : $urandom_range(4, 12));
      begin_frame(sg, np);
      feed(eff(np), 1, to, early);
      model(AW, sg, eff(np), d, ov);
      model(AW2, sg, eff(np), d2, ov2);
      checks++;
      if (to || early || out_valid !== 1'b1) begin
        failures++;
        $display("FAIL rnd_valid f=%0d: v=%b to=%b want 1",
                 f, out_valid, to);
      end
      checks++;
      if (out_data !== d[AW-1:0] || out_ovf !== ov) begin
        failures++;
        $display("FAIL rnd_acc36 f=%0d: d=%h o=%b want %h/%b",
                 f, out_data, out_ovf, d[AW-1:0], ov);
      end
      checks++;
      if (out_data2 !== d2[AW2-1:0] || out_ovf2 !== ov2) begin
        failures++;
        $display("FAIL rnd_acc24 f=%0d: d=%h o=%b want %h/%b",
                 f, out_data2, out_ovf2, d2[AW2-1:0], ov2);
      end
      end_frame;
    end
  endtask

  task automatic test_back_to_back;
    bit to, early, ov;
    logic [63:0] d;
    psq[0] = 1; psq[1] = 0; psq[2] = 1; psq[3] = 1;
    begin_frame(0, 4);
    feed(4, 0, to, early);
    for (int c = 0; c < 5; c++) begin
      start = 1'b1;
      cfg_planes = CW'(2);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || out_data !== 36'd11 ||
          psum_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_hold c=%0d: v=%b d=%0d r=%b want 1/11/0",
                 c, out_valid, out_data, psum_ready);
      end
    end
    rand_psums(0);
    out_ready = 1'b1;
    start = 1'b1;
    cfg_signed = 1'b1;
    cfg_planes = CW'(3);
    @(posedge clk); #1;
    out_ready = 1'b0;
    start = 1'b0;
    checks++;
    if (psum_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL b2b_restart: r=%b v=%b b=%b want 1/0/1",
               psum_ready, out_valid, busy);
    end
    feed(3, 0, to, early);
    model(AW, 1, 3, d, ov);
    checks++;
    if (to || out_data !== d[AW-1:0] || out_ovf !== ov) begin
      failures++;
      $display("FAIL b2b_result: d=%h o=%b want %h/%b",
               out_data, out_ovf, d[AW-1:0], ov);
    end
    end_frame;
  endtask

  task automatic test_gaps;
    bit to, early, ov;
    logic [63:0] d;
    rand_psums(2);
    model(AW, 1, NB, d, ov);
    begin_frame(1, 8);
    feed(NB, 0, to, early);
    checks++;
    if (to || out_data !== d[AW-1:0] || out_ovf !== ov) begin
      failures++;
      $display("FAIL gap_free: d=%h o=%b want %h/%b",
               out_data, out_ovf, d[AW-1:0], ov);
    end
    end_frame;
    begin_frame(1, 8);
    start = 1'b1;
    feed(NB, 2, to, early);
    start = 1'b0;
    checks++;
    if (to || early || out_data !== d[AW-1:0] || out_ovf !== ov) begin
      failures++;
      $display("FAIL gap_pattern: d=%h o=%b want %h/%b",
               out_data, out_ovf, d[AW-1:0], ov);
    end
    end_frame;
  endtask

  task automatic test_abort;
    bit to, early, ov;
    logic [63:0] d;
    rand_psums(0);
    begin_frame(0, 8);
    feed(2, 0, to, early);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || psum_ready !== 1'b0 || out_valid !== 1'b0 ||
        out_data !== '0 || out_ovf !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid: b=%b r=%b v=%b d=%h o=%b want 0",
               busy, psum_ready, out_valid, out_data, out_ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin_frame(0, 8);
    feed(2, 0, to, early);
    clr = 1'b1;
    psum_valid = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0;
    psum_valid = 1'b0;
    checks++;
    if (busy !== 1'b0 || psum_ready !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL clr_mid: b=%b r=%b v=%b want 0",
               busy, psum_ready, out_valid);
    end
    begin_frame(0, 8);
    feed(NB, 1, to, early);
    model(AW, 0, NB, d, ov);
    checks++;
    if (to || out_data !== d[AW-1:0] || out_ovf !== ov) begin
      failures++;
      $display("FAIL abort_next: d=%h o=%b want %h/%b",
               out_data, out_ovf, d[AW-1:0], ov);
    end
    end_frame;
  endtask

  task automatic test_ovf_narrow;
    bit to, early;
    longint full;
    logic [AW2-1:0] exp24;
    full = longint'(524287) * 255;
    exp24 = AW2'(full);
    for (int i = 0; i < NB; i++) psq[i] = 524287;
    for (int r = 0; r < 2; r++) begin
      begin_frame(0, (r == 0) ? 8 : 0);
      feed(NB, 0, to, early);
      checks++;
      if (to || out_ovf2 !== 1'b1 || out_data2 !== exp24) begin
        failures++;
        $display("FAIL ovf24 r=%0d: d=%h o=%b want %h/1",
                 r, out_data2, out_ovf2, exp24);
      end
      checks++;
      if (out_data !== AW'(full) || out_ovf !== 1'b0) begin
        failures++;
        $display("FAIL ovf36 r=%0d: d=%h o=%b want %h/0",
                 r, out_data, out_ovf, AW'(full));
      end
      end_frame;
    end
  endtask

  initial begin
    test_reset();
    test_unsigned();
    test_signed();
    test_random();
    test_back_to_back();
    test_gaps();
    test_abort();
    test_ovf_narrow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cim_shift_acc.md
Name: cim_shift_acc

Overview:
Bit-serial shift-accumulate stage for the digital CIM column datapath.
- Consumes one signed PSUM_W-bit adder-tree partial sum per input bit-plane, MSB plane first.
- Builds the ACC_W-bit dot-product result using acc = 2*acc ± psum, with a sign-weighted MSB plane for signed activations.
- Sits between the column adder tree (upstream) and the output/requant buffer (downstream), with valid/ready on both sides.

Parameters:
PSUM_W, 20, width of signed partial sum per bit-plane
ACC_W, 36, accumulator/result width (signed, two's complement)
IN_BITS, 8, maximum number of activation bit-planes per frame
CNT_W, $clog2(IN_BITS+1), width of plane count/config field (derived, not overridden)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous soft clear; returns to IDLE, drops frame
start  input  1  frame start pulse; sampled only in IDLE (or at DONE output handshake)
cfg_signed  input  1  1: activations signed (MSB plane weight negative); latched at start
cfg_planes  input  CNT_W  bit-planes in frame, 1..IN_BITS; 0 or >IN_BITS treated as IN_BITS; latched at start
psum_data  input  PSUM_W  signed partial sum for current plane
psum_valid  input  1  psum_data valid
psum_ready  output  1  stage accepts psum this cycle
out_data  output  ACC_W  signed accumulated result
out_ovf  output  1  sticky overflow for this frame
out_valid  output  1  result valid
out_ready  input  1  downstream accepts result
busy  output  1  high in ACC or DONE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; acc, plane_cnt, out_data, out_ovf, out_valid, psum_ready, busy all 0; latched config 0.
- States: IDLE, ACC, DONE. Single always_ff state register; next-state and outputs registered (psum_ready is a decode of registered state).
- IDLE: psum_ready=0, out_valid=0. start=1 -> latch cfg, acc<=0, plane_cnt<=0, ovf<=0, go ACC.
- ACC: psum_ready=1. Accept on psum_valid & psum_ready.
  - First plane (plane_cnt==0) with cfg_signed=1: acc <= 0 - sext(psum).
  - Otherwise: acc <= (acc<<1) + sext(psum).
  - sext = sign-extension of psum_data to ACC_W.
  - plane_cnt++ on each accept. The accept with plane_cnt==planes-1 loads out_data with the new acc, sets out_valid=1, and goes to DONE.
  - Latency: out_valid is high the cycle after the last psum accept.
  - No accept -> hold all state; no bubbles are inserted.
- DONE: psum_ready=0; out_data, out_ovf, out_valid held stable until out_ready=1.
  - On out_valid & out_ready: start=1 the same cycle -> latch new cfg and go ACC directly (back-to-back). Otherwise go IDLE and clear out_valid.
- start in ACC or in DONE without the handshake: ignored.
- Arithmetic: modulo 2^ACC_W wrap. out_ovf is sticky per frame and is set when either:
  - the shift drops significance (acc[ACC_W-1] != acc[ACC_W-2] before the shift), or
  - the add/sub has signed overflow (operand signs equal, result sign differs; negation of a PSUM_W min value is exact because it is done in ACC_W).
- clr: highest priority after reset. Next cycle state=IDLE, out_valid=0, psum_ready=0, acc=0. Any pending psum is not consumed.
- rst_n asserted mid-frame: immediate return to the reset values; the partial frame is discarded.
- psum_valid in IDLE or DONE: not accepted; upstream holds the data.

Decomposition:
- Shared package cim_pkg holds:
  - PSUM_W and ACC_W defaults
  - state enum typedef acc_state_t {IDLE, ACC, DONE}
  - typedef psum_t (logic signed [PSUM_W-1:0])
  - typedef acc_t (logic signed [ACC_W-1:0])
- One combinational sub-module, cim_acc_addsub. Inputs: acc, psum, sub, shift_en. Outputs: next_acc and ovf, performing the sign-extend, shift, add/subtract and overflow detection.
- FSM, counter and handshakes stay in cim_shift_acc.

Test Plan:
- Unsigned, cfg_planes=4, psums 1,0,1,1 back-to-back -> out_data=11, out_ovf=0; out_valid rises exactly 1 cycle after 4th accept.
- Signed, cfg_planes=4, psums 1,0,1,1 -> out_data=-5 (36'hF_FFFF_FFFB). Signed, cfg_planes=8, all psums -524288 -> out_data=524288, ovf=0.
- Backpressure: hold out_ready=0 for 5 cycles after result -> out_data/out_valid stable, psum_ready=0, start ignored; then out_ready=1 with start=1 -> next cycle state ACC, psum_ready=1, new frame result correct.
- psum_valid toggling 1,0,0,1,... during ACC -> only valid cycles counted; result identical to gap-free run.
- Reset mid-frame: rst_n low after 2 of 8 planes -> all outputs 0 asynchronously. Same for clr -> IDLE next cycle. Next full frame gives correct result.
- Override ACC_W=24, unsigned, cfg_planes=8, all psums 524287 -> out_ovf=1, out_data = (524287*255) mod 2^24. cfg_planes=0 -> behaves as 8 planes.
